// File: rtl/game_round_timer_ctrl_if.sv
// Control pulses and display/status outputs of the round timer.
// The master side is the game top level; the slave side is the timer.
interface game_round_timer_ctrl_if;
   logic       Start;
   logic       Pause;
   logic       Abort;
   logic [3:0] OnesValue;
   logic [3:0] TensValue;
   logic [2:0] State;
   logic       GameActive;
   logic       TimeUpPulse;
   logic       SecondTick;

   modport master (
      output Start, Pause, Abort,
      input  OnesValue, TensValue, State, GameActive, TimeUpPulse, SecondTick
   );

   modport slave (
      input  Start, Pause, Abort,
      output OnesValue, TensValue, State, GameActive, TimeUpPulse, SecondTick
   );
endinterface

// File: rtl/game_round_timer_ctrl.sv
// Round sequencer: one-second divider, two-digit BCD countdown and the
// idle/pregame/play/paused/timeup state machine behind the HEX display.
module game_round_timer_ctrl #(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int ROUND_SECONDS   = 60,
   parameter int PREGAME_SECONDS = 3
) (
   input logic                    ClockIn,
   input logic                    Reset,
   game_round_timer_ctrl_if.slave bus
);
   localparam int               DIV_W      = $clog2(CLOCK_FREQUENCY);
   localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLOCK_FREQUENCY - 1);
   localparam logic [3:0]       ROUND_TENS = 4'(ROUND_SECONDS / 10);
   localparam logic [3:0]       ROUND_ONES = 4'(ROUND_SECONDS % 10);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PREGAME = 3'd1,
      PLAY    = 3'd2,
      PAUSED  = 3'd3,
      TIMEUP  = 3'd4
   } state_t;

   // A zero-length countdown starts the round straight in PLAY.
   localparam state_t     START_STATE = (PREGAME_SECONDS == 0) ? PLAY : PREGAME;
   localparam logic [3:0] START_TENS  = (PREGAME_SECONDS == 0) ? ROUND_TENS : 4'd0;
   localparam logic [3:0] START_ONES  = (PREGAME_SECONDS == 0) ? ROUND_ONES : 4'(PREGAME_SECONDS);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       tens_q, tens_d, ones_q, ones_d;
   logic             tick_q, tick_d, ga_q, tup_q;
   logic             running, tick, at_zero, dec_zero;
   logic [3:0]       dec_tens, dec_ones;

   always_comb begin
      running  = (state_q == PREGAME) || (state_q == PLAY);
      tick     = running && (div_q == '0);
      at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
      dec_tens = tens_q;
      dec_ones = ones_q;
      if (!at_zero) begin
         if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
         end else begin
            dec_ones = ones_q - 4'd1;
         end
      end
      dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);

      state_d = state_q;
      div_d   = div_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      tick_d  = 1'b0;

      // The divider only runs while a countdown is live; otherwise it holds.
      if (running) div_d = tick ? DIV_LOAD : div_q - DIV_W'(1);
      if (tick) begin
         tens_d = dec_tens;
         ones_d = dec_ones;
         tick_d = 1'b1;
      end

      if (bus.Abort) begin
         state_d = IDLE;
         tens_d  = ROUND_TENS;
         ones_d  = ROUND_ONES;
         div_d   = DIV_LOAD;
         tick_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE, TIMEUP: begin
               if (bus.Start) begin
                  state_d = START_STATE;
                  tens_d  = START_TENS;
                  ones_d  = START_ONES;
                  div_d   = DIV_LOAD;
               end
            end
            PREGAME: begin
               if (bus.Start) begin
                  tens_d = START_TENS;
                  ones_d = START_ONES;
                  div_d  = DIV_LOAD;
                  tick_d = 1'b0;
               end else if (at_zero) begin
                  // The "0" of the countdown is shown for one cycle before play.
                  state_d = PLAY;
                  tens_d  = ROUND_TENS;
                  ones_d  = ROUND_ONES;
                  div_d   = DIV_LOAD;
               end
            end
            PLAY: begin
               if (tick && dec_zero) state_d = TIMEUP;
               else if (bus.Pause)   state_d = PAUSED;
            end
            PAUSED: begin
               if (bus.Pause) state_d = PLAY;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         state_q <= IDLE;
         div_q   <= DIV_LOAD;
         tens_q  <= ROUND_TENS;
         ones_q  <= ROUND_ONES;
         tick_q  <= 1'b0;
         ga_q    <= 1'b0;
         tup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         tick_q  <= tick_d;
         ga_q    <= (state_d == PLAY);
         tup_q   <= (state_d == TIMEUP) && (state_q != TIMEUP);
      end
   end

   assign bus.State       = state_q;
   assign bus.TensValue   = tens_q;
   assign bus.OnesValue   = ones_q;
   assign bus.SecondTick  = tick_q;
   assign bus.GameActive  = ga_q;
   assign bus.TimeUpPulse = tup_q;
endmodule
